// File: rtl/decode_stage.sv
// Registered RV32IM-subset decode stage with a 2-entry skid buffer.
// in_ready depends only on state, never on out_ready.
module decode_stage #(
    parameter int INSTR_SIZE = 32,
    parameter int PC_SIZE    = 32,
    parameter int REG_IDX    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_SIZE-1:0] in_instr,
    input  logic [PC_SIZE-1:0]    in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_SIZE-1:0]    out_pc,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic [REG_IDX-1:0]    out_rs1,
    output logic [REG_IDX-1:0]    out_rs2,
    output logic [REG_IDX-1:0]    out_rd,
    output logic [4:0]            out_fmt,
    output logic [PC_SIZE-1:0]    out_imm,
    output logic [PC_SIZE-1:0]    out_target,
    output logic                  out_illegal
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [PC_SIZE-1:0] pc;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [REG_IDX-1:0] rs1;
        logic [REG_IDX-1:0] rs2;
        logic [REG_IDX-1:0] rd;
        logic [4:0]         fmt;
        logic [PC_SIZE-1:0] imm;
        logic [PC_SIZE-1:0] target;
        logic               illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    entry_t view;

    logic [6:0]         op;
    logic [6:0]         f7;
    logic [REG_IDX-1:0] rs1_f, rs2_f, rd_f;
    logic [PC_SIZE-1:0] imm_i, imm_s, imm_b, imm_j;
    logic               accept, pop;

    assign op    = in_instr[6:0];
    assign f7    = in_instr[31:25];
    assign rs1_f = in_instr[15 +: REG_IDX];
    assign rs2_f = in_instr[20 +: REG_IDX];
    assign rd_f  = in_instr[7 +: REG_IDX];

    assign imm_i = {{(PC_SIZE-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(PC_SIZE-12){in_instr[31]}}, in_instr[31:25],
                    in_instr[11:7]};
    assign imm_b = {{(PC_SIZE-13){in_instr[31]}}, in_instr[31],
                    in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{(PC_SIZE-21){in_instr[31]}}, in_instr[31],
                    in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = op;
        dec.funct3 = in_instr[14:12];
        dec.funct7 = f7;
        unique case (1'b1)
            op == OP_ALU: begin
                if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) begin
                    dec.fmt = 5'b00001;
                    dec.rs1 = rs1_f;
                    dec.rs2 = rs2_f;
                    dec.rd  = rd_f;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            op == OP_IMM || op == OP_LOAD: begin
                dec.fmt = 5'b00010;
                dec.rs1 = rs1_f;
                dec.rd  = rd_f;
                dec.imm = imm_i;
            end
            op == OP_STORE: begin
                dec.fmt = 5'b00100;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.imm = imm_s;
            end
            op == OP_BRANCH: begin
                dec.fmt    = 5'b01000;
                dec.rs1    = rs1_f;
                dec.rs2    = rs2_f;
                dec.imm    = imm_b;
                dec.target = in_pc + imm_b;
            end
            op == OP_JAL: begin
                dec.fmt    = 5'b10000;
                dec.rd     = rd_f;
                dec.imm    = imm_j;
                dec.target = in_pc + imm_j;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && pop) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = SKID;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Outputs read as zero whenever nothing is presented.
    assign view = out_valid ? main_q : '0;

    assign out_pc      = view.pc;
    assign out_opcode  = view.opcode;
    assign out_funct3  = view.funct3;
    assign out_funct7  = view.funct7;
    assign out_rs1     = view.rs1;
    assign out_rs2     = view.rs2;
    assign out_rd      = view.rd;
    assign out_fmt     = view.fmt;
    assign out_imm     = view.imm;
    assign out_target  = view.target;
    assign out_illegal = view.illegal;

endmodule
